// File: rtl/maquina_estados_mascota_if.sv
// Signal bundle between the need-level block and the pet mood state machine.
// The master drives levels and test controls; the slave returns the mood state and feedback enables.
interface maquina_estados_mascota_if;
  logic [1:0] nivel_animo;
  logic [1:0] nivel_energia;
  logic [1:0] nivel_descanso;
  logic [1:0] nivel_medicina;
  logic       senal_mtest;
  logic       senal_test;
  logic [2:0] estado;
  logic       activo_comida;
  logic       activo_medicina;
  logic       muerto;
  logic       cambio_estado;

  modport master (
    output nivel_animo,
    output nivel_energia,
    output nivel_descanso,
    output nivel_medicina,
    output senal_mtest,
    output senal_test,
    input  estado,
    input  activo_comida,
    input  activo_medicina,
    input  muerto,
    input  cambio_estado
  );

  modport slave (
    input  nivel_animo,
    input  nivel_energia,
    input  nivel_descanso,
    input  nivel_medicina,
    input  senal_mtest,
    input  senal_test,
    output estado,
    output activo_comida,
    output activo_medicina,
    output muerto,
    output cambio_estado
  );
endinterface

// File: rtl/maquina_estados_mascota.sv
// Pet mood state machine: filtered candidate mood, illness-to-death timer and a manual test mode
// that steps through every mood so downstream gating can be exercised.
module maquina_estados_mascota #(
  parameter int unsigned FILTRO        = 4,
  parameter int unsigned CICLOS_MUERTE = 20
) (
  input logic                       clk,
  input logic                       reset,
  maquina_estados_mascota_if.slave  bus
);

  localparam int unsigned FiltroW = (FILTRO > 1) ? $clog2(FILTRO) : 1;
  localparam int unsigned MuerteW = (CICLOS_MUERTE > 1) ? $clog2(CICLOS_MUERTE) : 1;
  localparam logic [FiltroW-1:0] FiltroMax = FiltroW'(FILTRO - 1);
  localparam logic [MuerteW-1:0] MuerteMax = MuerteW'(CICLOS_MUERTE - 1);

  typedef enum logic [2:0] {
    StNeutral    = 3'd0,
    StFeliz      = 3'd1,
    StHambriento = 3'd2,
    StCansado    = 3'd3,
    StTriste     = 3'd4,
    StEnfermo    = 3'd5,
    StMuerto     = 3'd6
  } estado_e;

  estado_e              estado_q, estado_d;
  estado_e              cand, cand_q;
  logic [FiltroW-1:0]   filtro_cnt_q, filtro_cnt_d;
  logic [MuerteW-1:0]   muerte_cnt_q, muerte_cnt_d;
  logic                 mtest_q;
  logic                 mtest_rise, mtest_fall;
  logic                 cambio_q, comida_q, medicina_q, muerto_q;

  assign mtest_rise = bus.senal_mtest & ~mtest_q;
  assign mtest_fall = ~bus.senal_mtest & mtest_q;

  // Strict priority: the most urgent need wins.
  always_comb begin
    cand = StNeutral;
    if (bus.nivel_medicina == 2'd0) begin
      cand = StEnfermo;
    end else if (bus.nivel_energia == 2'd0) begin
      cand = StHambriento;
    end else if (bus.nivel_descanso == 2'd0) begin
      cand = StCansado;
    end else if (bus.nivel_animo == 2'd0) begin
      cand = StTriste;
    end else if (bus.nivel_animo[1] && bus.nivel_energia[1] &&
                 bus.nivel_descanso[1] && bus.nivel_medicina[1]) begin
      cand = StFeliz;
    end
  end

  always_comb begin
    estado_d     = estado_q;
    filtro_cnt_d = filtro_cnt_q;
    muerte_cnt_d = muerte_cnt_q;

    if (mtest_rise || mtest_fall) begin
      // Entering or leaving test mode always restarts from a clean neutral state.
      estado_d     = StNeutral;
      filtro_cnt_d = '0;
      muerte_cnt_d = '0;
    end else if (bus.senal_mtest) begin
      filtro_cnt_d = '0;
      muerte_cnt_d = '0;
      if (bus.senal_test) begin
        estado_d = (estado_q == StMuerto) ? StNeutral : estado_e'(estado_q + 3'd1);
      end
    end else if (estado_q != StMuerto) begin
      if ((cand != cand_q) || (cand == estado_q)) begin
        filtro_cnt_d = '0;
      end else if (filtro_cnt_q == FiltroMax) begin
        estado_d     = cand;
        filtro_cnt_d = '0;
      end else begin
        filtro_cnt_d = filtro_cnt_q + 1'b1;
      end

      // Evaluated after the filter so death overrides a simultaneous mood change.
      if (estado_q == StEnfermo) begin
        if (muerte_cnt_q == MuerteMax) begin
          estado_d     = StMuerto;
          muerte_cnt_d = '0;
        end else begin
          muerte_cnt_d = muerte_cnt_q + 1'b1;
        end
      end else begin
        muerte_cnt_d = '0;
      end
    end else begin
      filtro_cnt_d = '0;
      muerte_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q     <= StNeutral;
      cand_q       <= StNeutral;
      filtro_cnt_q <= '0;
      muerte_cnt_q <= '0;
      mtest_q      <= 1'b0;
      cambio_q     <= 1'b0;
      comida_q     <= 1'b0;
      medicina_q   <= 1'b0;
      muerto_q     <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      cand_q       <= cand;
      filtro_cnt_q <= filtro_cnt_d;
      muerte_cnt_q <= muerte_cnt_d;
      mtest_q      <= bus.senal_mtest;
      cambio_q     <= (estado_d != estado_q);
      comida_q     <= (estado_d == StHambriento);
      medicina_q   <= (estado_d == StEnfermo);
      muerto_q     <= (estado_d == StMuerto);
    end
  end

  assign bus.estado          = estado_q;
  assign bus.activo_comida   = comida_q;
  assign bus.activo_medicina = medicina_q;
  assign bus.muerto          = muerto_q;
  assign bus.cambio_estado   = cambio_q;

endmodule

// File: doc/maquina_estados_mascota.md
Name: maquina_estados_mascota

Overview:
Pet behaviour state machine directly downstream of the mode/level block. Consumes the four 2-bit need levels (animo, energia, descanso, medicina) plus the debounced test signals, and derives the pet's mood state with a stability filter and an illness-to-death timer. Drives the display/state code and feeds back the Activo_Comida / Activo_Medicina enables that gate the energia and medicina mode counters.

Parameters:
FILTRO, 4, consecutive cycles a new candidate state must hold before Estado changes (legal range >=1)
CICLOS_MUERTE, 20, consecutive cycles in ENFERMO before the transition to MUERTO (legal range >=1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
Nivel_Animo  input  2  animo level, 0 = empty, 3 = full
Nivel_Energia  input  2  energia level
Nivel_Descanso  input  2  descanso level
Nivel_Medicina  input  2  medicina level
Senal_MTest  input  1  test mode enable (level)
Senal_Test  input  1  single-cycle step pulse, debounced upstream
Estado  output  3  0 NEUTRAL, 1 FELIZ, 2 HAMBRIENTO, 3 CANSADO, 4 TRISTE, 5 ENFERMO, 6 MUERTO
Activo_Comida  output  1  high when Estado = HAMBRIENTO
Activo_Medicina  output  1  high when Estado = ENFERMO
Muerto  output  1  high when Estado = MUERTO
Cambio_Estado  output  1  one-cycle pulse on the cycle after any Estado change

Behaviour:
- Clock and reset: all logic on the rising edge of clk. Reset is synchronous, active-high, and overrides everything else.
- Reset values: Estado = 0, all other outputs = 0, internal counters = 0, cand_q = NEUTRAL.
- Outputs are registered. Activo_Comida, Activo_Medicina and Muerto update on the same edge as Estado. Cambio_Estado asserts on the edge where Estado takes a new value.
- Candidate state (cand) is combinational, evaluated in strict priority order:
  - Medicina = 0 -> ENFERMO
  - else Energia = 0 -> HAMBRIENTO
  - else Descanso = 0 -> CANSADO
  - else Animo = 0 -> TRISTE
  - else all four levels >= 2 -> FELIZ
  - else NEUTRAL
- Normal mode filter (Senal_MTest = 0, Estado != MUERTO):
  - cand_q <= cand every cycle.
  - If cand != cand_q or cand == Estado: filtro_cnt <= 0.
  - Else if filtro_cnt == FILTRO-1: Estado <= cand and filtro_cnt <= 0.
  - Else: filtro_cnt increments.
  - Net latency: a new cand that stays stable is first visible on Estado FILTRO+1 edges after it appears (5 edges at the default). A glitch shorter than that produces no change.
- Death timer:
  - muerte_cnt increments every cycle Estado = ENFERMO and clears whenever Estado != ENFERMO.
  - When muerte_cnt == CICLOS_MUERTE-1: Estado <= MUERTO.
  - Counting from the edge Estado became ENFERMO, MUERTO appears CICLOS_MUERTE edges later.
  - If the death and a filter transition fire on the same cycle, death wins.
- MUERTO is sticky in normal mode. Levels are ignored; only reset or entering test mode leaves it.
- Test mode:
  - On the rising edge of Senal_MTest (0 -> 1 versus its registered copy), Estado <= NEUTRAL and filtro_cnt and muerte_cnt are cleared.
  - While Senal_MTest = 1, levels are ignored. Each Senal_Test pulse advances Estado by 1, and 6 wraps to 0.
  - MUERTO is not sticky in test mode. The death timer is held at 0.
  - Activo_Comida, Activo_Medicina and Muerto follow Estado, so downstream gating can be exercised.
  - On the falling edge of Senal_MTest, Estado <= NEUTRAL, counters are cleared, and normal filtering resumes.
  - A Senal_Test pulse on the same cycle as the Senal_MTest rising edge is ignored; the result is NEUTRAL.
  - Senal_Test while Senal_MTest = 0 is ignored.
- Reset mid-operation (in a filter window, during the death count, or in test mode) returns everything to reset values on the next edge.

Test Plan:
- Reset held 2 cycles -> Estado=0, Activo_Comida=0, Activo_Medicina=0, Muerto=0, Cambio_Estado=0.
- All levels = 3 from reset -> Estado=1 (FELIZ) exactly 5 edges later, with a one-cycle Cambio_Estado=1 on that edge. Then Energia=0 held -> Estado=2 after 5 edges and Activo_Comida=1. Then Energia=0 held for only 3 cycles before returning to 3 -> no change.
- Medicina=0 and Energia=0 together -> Estado=5 (priority), Activo_Medicina=1. Hold 20 more edges -> Estado=6, Muerto=1. Then restore all levels to 3 for 50 cycles -> Estado stays 6.
- ENFERMO for 10 cycles, then Medicina=3 long enough to filter out -> muerte_cnt cleared. Re-enter ENFERMO -> a full 20 cycles is again required for MUERTO.
- Senal_MTest=1, then 8 Senal_Test pulses -> Estado sequence 0,1,2,3,4,5,6,0,1, with Activo_Medicina=1 only at 5. Drop Senal_MTest -> Estado=0, and normal filtering resumes.
- Reset asserted at filtro_cnt=2 and again while in MUERTO -> reset values on the next edge. After release, a full FILTRO window is required before the next change.
